// File: rtl/cpu_pkg.sv
`default_nettype none
// =============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch-path widths, halt encoding, FSM state and entry types.
// Revision : 1.0
// =============================================================================
package cpu_pkg;

   localparam int ADDR_W = 7;
   localparam int WORD_W = 32;
   localparam logic [WORD_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      FS_RESET = 2'd0,
      FS_RUN   = 2'd1,
      FS_HALT  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] word;
      logic [ADDR_W-1:0] pc;
   } fetch_entry_t;

   // Occupancy after one cycle of buffer activity.
   function automatic logic [1:0] next_count(input logic [1:0] count,
                                             input logic       push,
                                             input logic       pop);
      return count + {1'b0, push} - {1'b0, pop};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// =============================================================================
// Module   : fetch_unit_if
// Brief    : ROM, redirect and decode handshake bundle for fetch_unit.
//            Carries the halted flag only when FETCH_HALT_EN is defined.
// Revision : 1.0
// =============================================================================
interface fetch_unit_if #(
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int WORD_W = cpu_pkg::WORD_W
);

   logic [ADDR_W-1:0] rom_addr;
   logic              rom_en;
   logic [WORD_W-1:0] rom_data;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic [WORD_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
`ifdef FETCH_HALT_EN
   logic              halted;
`endif

   modport master (
`ifdef FETCH_HALT_EN
      output halted,
`endif
      output rom_addr,
      output rom_en,
      input  rom_data,
      input  redirect_valid,
      input  redirect_addr,
      output instr,
      output instr_pc,
      output instr_valid,
      input  instr_ready
   );

   modport slave (
`ifdef FETCH_HALT_EN
      input  halted,
`endif
      input  rom_addr,
      input  rom_en,
      output rom_data,
      output redirect_valid,
      output redirect_addr,
      input  instr,
      input  instr_pc,
      input  instr_valid,
      output instr_ready
   );

endinterface
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// =============================================================================
// Module   : fetch_buffer
// Brief    : Two-entry FIFO of fetched words with push/pop/flush and occupancy.
// Revision : 1.0
// =============================================================================
module fetch_buffer
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  fetch_entry_t i_entry,
   input  logic         i_pop,
   input  logic         i_flush,
   output fetch_entry_t o_head,
   output logic [1:0]   o_count
);

   fetch_entry_t r_mem [2];
   logic         r_rd_ptr;
   logic         r_wr_ptr;
   logic [1:0]   r_count;
   logic         w_pop;
   logic         w_push;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= next_count(r_count, w_push, w_pop);
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
   end

   assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '0;
   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// Module   : fetch_unit
// Brief    : PC, ROM issue, redirect/kill and decode buffering for instruction
//            fetch. Optional halt-on-HALT_WORD behind FETCH_HALT_EN.
// Revision : 1.0
// =============================================================================
module fetch_unit #(
   parameter int               ADDR_W   = cpu_pkg::ADDR_W,
   parameter int               WORD_W   = cpu_pkg::WORD_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic        clk,
   input  logic        reset,
   fetch_unit_if.master bus
);

   import cpu_pkg::*;

   fetch_state_t      r_state;
   fetch_state_t      w_state_nxt;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_tag;
   logic              r_inflight;
   logic [1:0]        w_count;
   logic [2:0]        w_load;
   logic              w_pop;
   logic              w_push;
   logic              w_issue;
   logic              w_redirect;
   fetch_entry_t      w_entry;
   fetch_entry_t      w_head;

   // Redirects are only honoured once the FSM has left RESET.
   assign w_redirect = bus.redirect_valid && (r_state != FS_RESET);
   assign w_pop      = (w_count != 2'd0) && bus.instr_ready;
   assign w_load     = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue    = (r_state == FS_RUN) && !bus.redirect_valid && (w_load < 3'd2);

   // Returned data is dropped when a redirect lands on it or fetch has halted.
   assign w_push     = r_inflight && !w_redirect && (r_state == FS_RUN);
   assign w_entry    = '{word: bus.rom_data, pc: r_tag};

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         FS_RESET: w_state_nxt = FS_RUN;
         FS_RUN: begin
`ifdef FETCH_HALT_EN
            if (w_push && (bus.rom_data == HALT_WORD)) w_state_nxt = FS_HALT;
`endif
         end
         FS_HALT: begin
            if (w_redirect) w_state_nxt = FS_RUN;
         end
         default: w_state_nxt = FS_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= FS_RESET;
         r_pc       <= RESET_PC;
         r_tag      <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= w_issue;
         if (w_issue) r_tag <= r_pc;
         if (w_redirect)   r_pc <= bus.redirect_addr;
         else if (w_issue) r_pc <= r_pc + 1'b1;
      end
   end

   fetch_buffer u_buffer (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_entry (w_entry),
      .i_pop   (w_pop),
      .i_flush (w_redirect),
      .o_head  (w_head),
      .o_count (w_count)
   );

   assign bus.rom_addr    = r_pc;
   assign bus.rom_en      = w_issue;
   assign bus.instr       = w_head.word;
   assign bus.instr_pc    = w_head.pc;
   assign bus.instr_valid = (w_count != 2'd0);
`ifdef FETCH_HALT_EN
   assign bus.halted      = (r_state == FS_HALT);
`endif

endmodule
`default_nettype wire
